// File: rtl/phy_link_nlane_pkg.sv
// Shared types and default codes for the N-lane serial PHY link.
package phy_link_nlane_pkg;

    typedef enum logic {TxTrain, TxFrame} tx_state_e;

    typedef enum logic [1:0] {RxHunt, RxAlign, RxLocked} rx_state_e;

    localparam logic [7:0] DEF_COM = 8'hBC;
    localparam logic [7:0] DEF_IDL = 8'h7C;

    // One symbol is the K flag followed by the payload.
    function automatic int unsigned sym_bits(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/phy_link_nlane_if.sv
// Parallel lane bus of the PHY link: TX capture side and RX delivery side.
interface phy_link_nlane_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 8
);
    logic [LANES*WIDTH-1:0] in_data;
    logic [LANES-1:0]       in_valid;
    logic                   peer_ready;
    logic                   tx_take;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_valid;
    logic                   rx_active;
    logic                   err_pulse;

    modport master (
        output in_data, in_valid, peer_ready,
        input  tx_take, out_data, out_valid, rx_active, err_pulse
    );

    modport slave (
        input  in_data, in_valid, peer_ready,
        output tx_take, out_data, out_valid, rx_active, err_pulse
    );
endinterface

// File: rtl/phy_link_nlane_rx.sv
// Receive side: bit-level COM hunt, symbol alignment, lock/loss tracking and lane demux.
module phy_link_nlane_rx
    import phy_link_nlane_pkg::*;
#(
    parameter int unsigned      LANES      = 4,
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(DEF_COM),
    parameter logic [WIDTH-1:0] IDL        = WIDTH'(DEF_IDL),
    parameter int unsigned      SYNC_COUNT = 4,
    parameter int unsigned      LOSS_COUNT = 2
) (
    input  logic                   clk_32f,
    input  logic                   rst,
    input  logic                   serial_in,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_valid,
    output logic                   rx_active,
    output logic                   err_pulse
);
    localparam int unsigned SYM    = sym_bits(WIDTH);
    localparam int unsigned BIT_W  = $clog2(SYM);
    localparam int unsigned SLOT_W = $clog2(LANES + 2);
    localparam int unsigned SYNC_W = $clog2(SYNC_COUNT + 1);
    localparam int unsigned LOSS_W = $clog2(LOSS_COUNT + 1);

    rx_state_e              state_q, state_d;
    logic [SYM-1:0]         shreg_q;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [SYNC_W-1:0]      cnt_q, cnt_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [LOSS_W-1:0]      miss_q, miss_d;
    logic [LANES*WIDTH-1:0] data_d;
    logic [LANES-1:0]       valid_d;
    logic                   err_d;
    logic                   boundary, is_com, is_idl, is_data;

    assign boundary = (bit_q == BIT_W'(SYM - 1));
    assign is_com   = (shreg_q == {1'b1, COM});
    assign is_idl   = (shreg_q == {1'b1, IDL});
    assign is_data  = !shreg_q[SYM-1];

    always_comb begin
        state_d = state_q;
        bit_d   = boundary ? '0 : bit_q + BIT_W'(1);
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        miss_d  = miss_q;
        data_d  = out_data;
        valid_d = '0;
        err_d   = 1'b0;
        unique case (state_q)
            RxHunt: begin
                if (is_com) begin
                    bit_d   = '0;
                    cnt_d   = SYNC_W'(1);
                    slot_d  = SLOT_W'(1);
                    miss_d  = '0;
                    state_d = (SYNC_COUNT <= 1) ? RxLocked : RxAlign;
                end
            end
            RxAlign: begin
                if (boundary) begin
                    if (is_com) begin
                        cnt_d = cnt_q + SYNC_W'(1);
                        if (cnt_d == SYNC_W'(SYNC_COUNT)) begin
                            state_d = RxLocked;
                            slot_d  = SLOT_W'(1);
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = RxHunt;
                    end
                end
            end
            RxLocked: begin
                if (boundary) begin
                    if (is_com) begin
                        slot_d = SLOT_W'(1);
                        miss_d = '0;
                    end else if (slot_q == SLOT_W'(LANES + 1)) begin
                        // The COM slot held something else: count a miss and resume at slot 1.
                        err_d  = 1'b1;
                        slot_d = SLOT_W'(1);
                        miss_d = miss_q + LOSS_W'(1);
                        if (miss_d == LOSS_W'(LOSS_COUNT)) state_d = RxHunt;
                    end else begin
                        if (is_data) begin
                            for (int i = 0; i < int'(LANES); i++) begin
                                if (slot_q == SLOT_W'(i + 1)) begin
                                    data_d[i*WIDTH +: WIDTH] = shreg_q[WIDTH-1:0];
                                    valid_d[i]               = 1'b1;
                                end
                            end
                        end else if (!is_idl) begin
                            err_d = 1'b1;
                        end
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            default: state_d = RxHunt;
        endcase
    end

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            state_q   <= RxHunt;
            shreg_q   <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            slot_q    <= '0;
            miss_q    <= '0;
            out_data  <= '0;
            out_valid <= '0;
            rx_active <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= {shreg_q[SYM-2:0], serial_in};
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            miss_q    <= miss_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            rx_active <= (state_d == RxLocked);
            err_pulse <= err_d;
        end
    end

endmodule

// File: rtl/phy_link_nlane_tx.sv
// Transmit side: COM training, then frames of COM plus one symbol per lane, MSB-first serializer.
module phy_link_nlane_tx
    import phy_link_nlane_pkg::*;
#(
    parameter int unsigned     LANES = 4,
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] COM  = WIDTH'(DEF_COM),
    parameter logic [WIDTH-1:0] IDL  = WIDTH'(DEF_IDL)
) (
    input  logic                   clk_32f,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_valid,
    input  logic                   peer_ready,
    output logic                   tx_take,
    output logic                   serial_out
);
    localparam int unsigned SYM    = sym_bits(WIDTH);
    localparam int unsigned BIT_W  = $clog2(SYM);
    localparam int unsigned SLOT_W = $clog2(LANES + 1);

    tx_state_e              state_q, state_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [LANES*WIDTH-1:0] data_q;
    logic [LANES-1:0]       valid_q;
    logic [SYM-1:0]         sym;
    logic                   last_bit;

    assign last_bit = (bit_q == BIT_W'(SYM - 1));
    // Capture happens while the frame COM's first bit is being loaded into serial_out.
    assign tx_take  = (state_q == TxFrame) && (slot_q == '0) && (bit_q == '0);

    always_comb begin
        sym = {1'b1, COM};
        if (state_q == TxFrame) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (slot_q == SLOT_W'(i + 1)) begin
                    sym = valid_q[i] ? {1'b0, data_q[i*WIDTH +: WIDTH]} : {1'b1, IDL};
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        bit_d   = last_bit ? '0 : bit_q + BIT_W'(1);
        if (last_bit) begin
            unique case (state_q)
                TxTrain: begin
                    if (peer_ready) begin
                        state_d = TxFrame;
                        slot_d  = '0;
                    end
                end
                TxFrame: begin
                    if (slot_q != SLOT_W'(LANES)) begin
                        slot_d = slot_q + SLOT_W'(1);
                    end else begin
                        slot_d = '0;
                        if (!peer_ready) state_d = TxTrain;
                    end
                end
                default: state_d = TxTrain;
            endcase
        end
    end

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            state_q    <= TxTrain;
            bit_q      <= '0;
            slot_q     <= '0;
            data_q     <= '0;
            valid_q    <= '0;
            serial_out <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            slot_q     <= slot_d;
            serial_out <= sym[BIT_W'(SYM - 1) - bit_q];
            if (tx_take) begin
                data_q  <= in_data;
                valid_q <= in_valid;
            end
        end
    end

endmodule

// File: rtl/phy_link_nlane.sv
// N-lane serial PHY link top: independent TX and RX halves sharing one bit clock.
module phy_link_nlane
    import phy_link_nlane_pkg::*;
#(
    parameter int unsigned      LANES      = 4,
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(DEF_COM),
    parameter logic [WIDTH-1:0] IDL        = WIDTH'(DEF_IDL),
    parameter int unsigned      SYNC_COUNT = 4,
    parameter int unsigned      LOSS_COUNT = 2
) (
    input  logic              clk_32f,
    input  logic              rst,
    phy_link_nlane_if.slave   bus,
    output logic              serial_out,
    input  logic              serial_in
);

    phy_link_nlane_tx #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .COM   (COM),
        .IDL   (IDL)
    ) u_tx (
        .clk_32f    (clk_32f),
        .rst        (rst),
        .in_data    (bus.in_data),
        .in_valid   (bus.in_valid),
        .peer_ready (bus.peer_ready),
        .tx_take    (bus.tx_take),
        .serial_out (serial_out)
    );

    phy_link_nlane_rx #(
        .LANES      (LANES),
        .WIDTH      (WIDTH),
        .COM        (COM),
        .IDL        (IDL),
        .SYNC_COUNT (SYNC_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    ) u_rx (
        .clk_32f   (clk_32f),
        .rst       (rst),
        .serial_in (serial_in),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .rx_active (bus.rx_active),
        .err_pulse (bus.err_pulse)
    );

endmodule

// File: tb/tb_phy_link_nlane.sv
// Loopback bench for phy_link_nlane: latency-based lane scoreboard plus directed scenarios.
module tb_phy_link_nlane;
    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int SYM   = WIDTH + 1;
    localparam int FRAME = SYM * (LANES + 1);

    logic clk_32f = 1'b0;
    logic rst     = 1'b1;
    logic serial_out, serial_in;
    logic inv     = 1'b0;
    int   dsel    = 0;
    logic [15:0] dly;

    always #5 clk_32f = ~clk_32f;

    phy_link_nlane_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    phy_link_nlane #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk_32f    (clk_32f),
        .rst        (rst),
        .bus        (bus),
        .serial_out (serial_out),
        .serial_in  (serial_in)
    );

    // Loopback channel with selectable bit delay and optional inversion.
    always @(posedge clk_32f or posedge rst) begin
        if (rst) dly <= '0;
        else     dly <= {dly[14:0], serial_out};
    end
    assign serial_in = ((dsel == 0) ? serial_out : dly[dsel-1]) ^ inv;

    typedef struct {
        int               cyc;
        int               lane;
        logic [WIDTH-1:0] data;
    } ev_t;

    ev_t              exp_q[$];
    logic [WIDTH-1:0] mdl_data [LANES];
    bit               known    [LANES];
    bit               model_en = 1'b0;
    int               ncyc     = 0;
    int               checks   = 0;
    int               errors   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a lane captured at tx_take reappears at +2+(lane+2)*SYM plus channel delay.
    initial begin
        logic [LANES-1:0] exp_v;
        ev_t ev;
        forever begin
            @(negedge clk_32f);
            ncyc++;
            exp_v = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc <= ncyc) begin
                ev = exp_q.pop_front();
                if (ev.cyc == ncyc && model_en) begin
                    exp_v[ev.lane]     = 1'b1;
                    mdl_data[ev.lane]  = ev.data;
                    known[ev.lane]     = 1'b1;
                end
            end
            check("valid/err exclusive", 64'(bus.err_pulse & (|bus.out_valid)), 64'd0);
            if (model_en) begin
                check("out_valid", 64'(bus.out_valid), 64'(exp_v));
                check("err_pulse", 64'(bus.err_pulse), 64'd0);
                check("rx_active held", 64'(bus.rx_active), 64'd1);
                for (int i = 0; i < LANES; i++) begin
                    if (known[i]) check("out_data lane", 64'(bus.out_data[i*WIDTH +: WIDTH]),
                                        64'(mdl_data[i]));
                end
                if (bus.tx_take) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (bus.in_valid[i]) begin
                            exp_q.push_back('{ncyc + 2 + (i + 2) * SYM + dsel, i,
                                              bus.in_data[i*WIDTH +: WIDTH]});
                        end
                    end
                end
            end
        end
    end

    task automatic model_clear(input bit zero);
        exp_q.delete();
        for (int i = 0; i < LANES; i++) begin
            mdl_data[i] = '0;
            known[i]    = zero;
        end
    endtask

    task automatic do_reset();
        model_en = 1'b0;
        bus.peer_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        model_clear(1'b1);
        rst = 1'b0;
    endtask

    task automatic wait_lock(input string name);
        int n = 0;
        while (!bus.rx_active && n < 400) begin
            @(negedge clk_32f);
            n++;
        end
        check(name, 64'(bus.rx_active), 64'd1);
    endtask

    task automatic wait_take(input string name);
        int n = 0;
        do begin
            @(negedge clk_32f);
            n++;
        end while (!bus.tx_take && n < 200);
        check(name, 64'(bus.tx_take), 64'd1);
    endtask

    task automatic start_frames(input logic [LANES*WIDTH-1:0] d, input logic [LANES-1:0] v);
        @(posedge clk_32f);
        #1;
        bus.in_data    = d;
        bus.in_valid   = v;
        bus.peer_ready = 1'b1;
        model_en       = 1'b1;
    endtask

    // Right after reset release with peer_ready low: pure COM stream, lock on the 38th edge.
    task automatic train_check();
        logic [SYM-1:0] com_sym = 9'h1BC;
        int lock_k = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk_32f);
            check("train serial_out", 64'(serial_out), 64'(com_sym[SYM-1-((k-1)%SYM)]));
            check("train tx_take", 64'(bus.tx_take), 64'd0);
            check("train out_valid", 64'(bus.out_valid), 64'd0);
            if (lock_k == 0 && bus.rx_active) lock_k = k;
        end
        check("lock edge", 64'(lock_k), 64'd38);
    endtask

    initial begin
        int cnt [LANES];
        int errs;
        logic [LANES*WIDTH-1:0] pat;

        bus.in_data    = '0;
        bus.in_valid   = '0;
        bus.peer_ready = 1'b0;

        // 1: reset values and training
        do_reset();
        check("reset out_data", 64'(bus.out_data), 64'd0);
        check("reset rx_active", 64'(bus.rx_active), 64'd0);
        train_check();

        // 2: full frames, pinned latencies
        start_frames(32'h44332211, 4'hF);
        wait_take("take frame");
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk_32f);
            if (k == 20) check("lane0 @20", 64'(bus.out_valid), 64'h1);
            if (k == 29) check("lane1 @29", 64'(bus.out_valid), 64'h2);
            if (k == 38) check("lane2 @38", 64'(bus.out_valid), 64'h4);
            if (k == 47) check("lane3 @47", 64'(bus.out_valid), 64'h8);
        end
        check("frame data", 64'(bus.out_data), 64'h44332211);

        // 3: partial valid, lanes 1/3 hold
        wait_take("take pre-partial");
        @(posedge clk_32f);
        #1;
        bus.in_data  = 32'hD4C3B2A1;
        bus.in_valid = 4'b0101;
        wait_take("take partial");
        for (int i = 0; i < LANES; i++) cnt[i] = 0;
        errs = 0;
        for (int k = 1; k <= 4 * FRAME; k++) begin
            @(negedge clk_32f);
            if (k >= 5) for (int i = 0; i < LANES; i++) cnt[i] += int'(bus.out_valid[i]);
            errs += int'(bus.err_pulse);
        end
        check("partial lane0 pulses", 64'(cnt[0]), 64'd4);
        check("partial lane1 pulses", 64'(cnt[1]), 64'd0);
        check("partial lane2 pulses", 64'(cnt[2]), 64'd4);
        check("partial lane3 pulses", 64'(cnt[3]), 64'd0);
        check("partial err", 64'(errs), 64'd0);
        check("partial data", 64'(bus.out_data), 64'h44C322A1);

        // 4: inverted channel for two frames drops lock, then relock
        wait_take("take pre-invert");
        model_en = 1'b0;
        @(posedge clk_32f);
        #1;
        inv  = 1'b1;
        errs = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk_32f);
            errs += int'(bus.err_pulse);
        end
        inv = 1'b0;
        check("loss err_pulse >= 2", 64'(errs >= 2), 64'd1);
        check("loss rx_active", 64'(bus.rx_active), 64'd0);
        bus.peer_ready = 1'b0;
        model_clear(1'b0);
        wait_lock("relock");
        start_frames(32'h44332211, 4'hF);
        repeat (4 * FRAME) @(negedge clk_32f);
        check("relock data", 64'(bus.out_data), 64'h44332211);

        // 5: channel delays 0..8 plus one random pick
        for (int n = 0; n <= 9; n++) begin
            int d;
            d = (n < 9) ? n : int'($urandom_range(0, 8));
            do_reset();
            dsel = d;
            wait_lock("lock with delay");
            pat = {8'hA0 + 8'(d), 8'hB0 + 8'(d), 8'hC0 + 8'(d), 8'hD0 + 8'(d)};
            start_frames(pat, 4'hF);
            repeat (3 * FRAME + 60) @(negedge clk_32f);
            check("delay data", 64'(bus.out_data), 64'(pat));
        end

        // 6: asynchronous reset mid-frame
        wait_take("take pre-reset");
        repeat (25) @(negedge clk_32f);
        model_en = 1'b0;
        @(posedge clk_32f);
        #2;
        rst = 1'b1;
        bus.peer_ready = 1'b0;
        #1;
        check("async serial_out", 64'(serial_out), 64'd0);
        check("async tx_take", 64'(bus.tx_take), 64'd0);
        check("async out_data", 64'(bus.out_data), 64'd0);
        check("async out_valid", 64'(bus.out_valid), 64'd0);
        check("async rx_active", 64'(bus.rx_active), 64'd0);
        check("async err_pulse", 64'(bus.err_pulse), 64'd0);
        dsel = 0;
        @(negedge clk_32f);
        model_clear(1'b1);
        rst = 1'b0;
        train_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
